// File: rtl/cpu_pkg.sv
// Shared types and default sizes for the register-bank write arbiter.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;

  // (a + b) mod n for operands already below n, so no divider is needed
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin scan: first set bit of eligible at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] pos [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pos
      assign pos[gi] = IW'(wrap_add(int'(ptr), gi, NREQ));
    end
  endgenerate

  // Scan from the far end so the candidate closest to ptr overwrites the rest
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[pos[k]]) begin
        valid = 1'b1;
        idx   = pos[k];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register bank's single write port: registered
// one-hot grant, one-hot register enable and shared write data.
module regfile_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = DEF_AW,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREGS-1:0]      wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  state_t           state_reg, state_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    last_reg, last_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [NREGS-1:0] wr_en_reg, wr_en_next;
  logic [WIDTH-1:0] wr_data_reg, wr_data_next;

  logic [AW-1:0]    addr_arr [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];
  logic [NREQ-1:0]  mask, eligible, sel;
  logic [NREGS-1:0] dec;
  logic             win_valid;
  logic [IW-1:0]    win_idx;
  logic [AW-1:0]    win_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      // Last winner is still dropping req this cycle; ignore it once
      assign mask[gi]     = (state_reg == GNT) && (last_reg == IW'(gi));
      assign sel[gi]      = (win_idx == IW'(gi));
    end
  endgenerate

  assign eligible = req & ~mask;
  assign busy     = |eligible;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .valid    (win_valid),
    .idx      (win_idx)
  );

  assign win_addr = addr_arr[win_idx];

  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_dec
      assign dec[gi] = (win_addr == AW'(gi)) && !((ZERO_REG != 0) && (gi == 0));
    end
  endgenerate

  always_comb begin
    state_next   = IDLE;
    ptr_next     = ptr_reg;
    last_next    = last_reg;
    grant_next   = '0;
    wr_en_next   = '0;
    wr_data_next = wr_data_reg;
    if (win_valid) begin
      state_next   = GNT;
      grant_next   = sel;
      wr_en_next   = dec;
      wr_data_next = data_arr[win_idx];
      ptr_next     = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      last_next    = win_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      last_reg    <= '0;
      grant_reg   <= '0;
      wr_en_reg   <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      wr_en_reg   <= wr_en_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign grant   = grant_reg;
  assign wr_en   = wr_en_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, reset/glitch sequences,
// and random traffic against a round-robin reference model.
module tb_regfile_wr_arbiter;

  localparam int NREQ  = 3;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       grant, grant_nz;
  logic [NREGS-1:0]      wr_en, wr_en_nz;
  logic [WIDTH-1:0]      wr_data, wr_data_nz;
  logic                  busy, busy_nz;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NREQ(NREQ), .NREGS(NREGS), .AW(AW), .WIDTH(WIDTH), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  regfile_wr_arbiter #(
    .NREQ(NREQ), .NREGS(NREGS), .AW(AW), .WIDTH(WIDTH), .ZERO_REG(0)
  ) u_dut_nz (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant_nz), .wr_en(wr_en_nz), .wr_data(wr_data_nz), .busy(busy_nz)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] a0, a1, a2;
    logic [7:0] d0, d1, d2;
    logic [2:0] g;
    logic [7:0] we;
    logic [7:0] wnz;
    logic [7:0] wd;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase state and reference model
  int               m_ptr, m_last, w, idx;
  logic [WIDTH-1:0] m_wd;
  logic [AW-1:0]    ra [NREQ];
  logic [WIDTH-1:0] rd [NREQ];
  logic [NREQ-1:0]  eg;
  logic [NREGS-1:0] ew, ewz;
  logic             eb;

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    tick();
    tick();
    chk("rst grant", grant, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 0);

    // Reset asserted while a grant is high clears outputs without a clock edge
    reset    = 1'b0;
    req      = 3'b010;
    req_addr = {3'd0, 3'd4, 3'd6};
    req_data = {8'h00, 8'h77, 8'h3C};
    tick();
    chk("mid grant", grant, 3'b010);
    chk("mid wr_en", wr_en, 8'h10);
    #2 reset = 1'b1;
    #1;
    chk("async grant", grant, 0);
    chk("async wr_en", wr_en, 0);
    chk("async wr_data", wr_data, 0);
    req = 3'b111;
    @(negedge clk) reset = 1'b0;
    tick();
    chk("post-rst grant", grant, 3'b001);
    chk("post-rst wr_en", wr_en, 8'h40);
    chk("post-rst wr_data", wr_data, 8'h3C);

    // Directed table starts from a clean reset
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    //        req     a0    a1    a2    d0     d1     d2     grant   we     we(nz) wd
    vt[0]  = '{3'b001, 3'd5, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 3'b001, 8'h20, 8'h20, 8'hA5};
    vt[1]  = '{3'b001, 3'd5, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'hA5};
    vt[2]  = '{3'b001, 3'd5, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 3'b001, 8'h20, 8'h20, 8'hA5};
    vt[3]  = '{3'b001, 3'd5, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'hA5};
    vt[4]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b010, 8'h04, 8'h04, 8'h22};
    vt[5]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b100, 8'h08, 8'h08, 8'h33};
    vt[6]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b001, 8'h02, 8'h02, 8'h11};
    vt[7]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b010, 8'h04, 8'h04, 8'h22};
    vt[8]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b100, 8'h08, 8'h08, 8'h33};
    vt[9]  = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b001, 8'h02, 8'h02, 8'h11};
    vt[10] = '{3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b010, 8'h04, 8'h04, 8'h22};
    vt[11] = '{3'b001, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b001, 8'h02, 8'h02, 8'h11};
    vt[12] = '{3'b000, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b000, 8'h00, 8'h00, 8'h11};
    vt[13] = '{3'b100, 3'd1, 3'd2, 3'd0, 8'h11, 8'h22, 8'hFF, 3'b100, 8'h00, 8'h01, 8'hFF};
    vt[14] = '{3'b000, 3'd1, 3'd2, 3'd0, 8'h11, 8'h22, 8'hFF, 3'b000, 8'h00, 8'h00, 8'hFF};

    for (int i = 0; i < 15; i++) begin
      req      = vt[i].req;
      req_addr = {vt[i].a2, vt[i].a1, vt[i].a0};
      req_data = {vt[i].d2, vt[i].d1, vt[i].d0};
      tick();
      chk($sformatf("v%0d grant", i), grant, vt[i].g);
      chk($sformatf("v%0d wr_en", i), wr_en, vt[i].we);
      chk($sformatf("v%0d wr_en nz", i), wr_en_nz, vt[i].wnz);
      chk($sformatf("v%0d wr_data", i), wr_data, vt[i].wd);
    end

    // req raised and dropped between edges: busy for that window only, no grant
    req = 3'b001;
    #2;
    chk("glitch busy hi", busy, 1);
    req = 3'b000;
    #1;
    chk("glitch busy lo", busy, 0);
    tick();
    chk("glitch grant", grant, 0);
    chk("glitch wr_en", wr_en, 0);

    // Random traffic against the reference model
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    m_ptr  = 0;
    m_last = -1;
    m_wd   = '0;
    for (int c = 0; c < 400; c++) begin
      req = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = AW'($urandom_range(0, 7));
        rd[i] = WIDTH'($urandom_range(0, 255));
        req_addr[i*AW +: AW]       = ra[i];
        req_data[i*WIDTH +: WIDTH] = rd[i];
      end
      eb = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (req[i] && i != m_last) eb = 1'b1;
      #1;
      chk($sformatf("r%0d busy", c), busy, eb);
      chk($sformatf("r%0d busy nz", c), busy_nz, eb);
      tick();
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req[idx] && idx != m_last) w = idx;
      end
      if (w >= 0) begin
        eg     = NREQ'(1) << w;
        ewz    = NREGS'(1) << ra[w];
        ew     = (ra[w] == 0) ? '0 : ewz;
        m_wd   = rd[w];
        m_ptr  = (w + 1) % NREQ;
        m_last = w;
      end else begin
        eg     = '0;
        ew     = '0;
        ewz    = '0;
        m_last = -1;
      end
      chk($sformatf("r%0d grant", c), grant, eg);
      chk($sformatf("r%0d wr_en", c), wr_en, ew);
      chk($sformatf("r%0d wr_data", c), wr_data, m_wd);
      chk($sformatf("r%0d grant nz", c), grant_nz, eg);
      chk($sformatf("r%0d wr_en nz", c), wr_en_nz, ewz);
      chk($sformatf("r%0d wr_data nz", c), wr_data_nz, m_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
